pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised ID/EX-style pipeline stage register carrying a control word, two register indices, NDATA data operands and an immediate between decode and execute. Replaces fixed-width stall-only stage registers with a valid/ready handshake, bubble-inserting flush and an optional two-entry skid buffer. A saturating stall counter supports performance analysis. Sits between the decode stage and the ALU/execute stage of the filter processor pipeline.

## Interface
- CTRL_W, 15, control word width
- RIDX_W, 4, register index width (Ra, Rb)
- DATA_W, 32, width of each data operand
- NDATA, 5, number of data operands (DatA, DatB, Off21, OffStore, Robj)
- IMM_W, 4, immediate width
- CNT_W, 16, stall counter width
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries; insert bubble
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word this cycle
- in_ctrl  in  CTRL_W  control word
- in_ra, in_rb  in  RIDX_W  source register indices
- in_data  in  NDATA*DATA_W  operands, operand k at bits [k*DATA_W +: DATA_W]
- in_imm  in  IMM_W  immediate
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts; low = stall
- out_ctrl, out_ra, out_rb, out_data, out_imm  out  as inputs  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- State machine (skid build): EMPTY (no entry), FULL (main entry only), SKID (main + skid entry).
  - EMPTY: in xfer -> FULL, load main.
  - FULL: in xfer & out xfer -> FULL, main reloaded; in xfer only -> SKID, word into skid; out xfer only -> EMPTY.
  - SKID: in_ready=0; out xfer -> FULL, skid moves to main; otherwise hold.
- in_ready = (state != SKID), driven from state register only (no combinational path from out_ready).
- Outputs always driven from main entry; out_valid = (state != EMPTY).
- Flush: highest priority after rst; next state EMPTY, main and skid ctrl cleared to 0 (bubble = all-zero ctrl, no side effects); in-flight in xfer that cycle is dropped. Data/index/imm fields not cleared.
- Payload fields held unchanged while not loaded; no payload change on stall.
- stall_cnt increments when out_valid & !out_ready, saturates at 2^CNT_W-1; cleared only by rst (not by flush).
- rst: state EMPTY, all outputs 0 (out_valid, out_ctrl, out_ra, out_rb, out_data, out_imm, stall_cnt); in_ready=1 in cycle after rst deasserts.

## Timing
- Latency: 1 cycle in -> out (word presented at in on edge N appears at out after edge N).
- Throughput: 1 word/cycle while out_ready=1.
- out_ready falls with stage FULL and new word arriving: word captured in skid, in_ready falls the next cycle; no word lost.
- Simultaneous flush and in xfer: flush wins, word discarded.
- rst mid-operation: all entries discarded, outputs reset next edge.
- stall_cnt updates one cycle after the stalled cycle.

## Configuration
- PIPE_STAGE_SKID_EN defined: behaviour above (SKID state, registered in_ready).
- Not defined: single entry, states EMPTY/FULL only; in_ready = !out_valid | out_ready (combinational from out_ready); same latency, throughput and flush/reset rules, no skid storage.

## Structure
- Shared package pipe_pkg: default widths (CTRL_W=15, RIDX_W=4, DATA_W=32, IMM_W=4), state enum {EMPTY, FULL, SKID}, bubble ctrl constant CTRL_NOP=0, packed payload struct type.
- One sub-module: pipe_sat_counter (parametrised CNT_W saturating counter with sync reset) for stall_cnt.

## Test plan
- Reset: hold rst 2 cycles -> out_valid=0, all payload 0, stall_cnt=0, in_ready=1 after release.
- Streaming: in_valid=1, out_ready=1, ctrl 1..10, data[0]=0xA0..0xA9 -> same sequence at out one cycle later, no gaps.
- Stall/skid: FULL with ctrl=3, out_ready=0 while ctrl=4 arrives -> in_ready drops next cycle, out holds ctrl=3; release -> 3 then 4, none lost; stall_cnt equals stalled cycles.
- Flush: SKID with ctrl=7,8, flush=1 with in_valid ctrl=9 -> next cycle out_valid=0, out_ctrl=0, ctrl 9 never appears.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15, stays 15.
- Build without PIPE_STAGE_SKID_EN: repeat stall test -> in_ready follows out_ready same cycle, ordering preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, state encoding and payload layout for pipe_stage_reg.
// Optional skid buffer is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

  localparam int unsigned DEF_CTRL_W = 15;
  localparam int unsigned DEF_RIDX_W = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IMM_W  = 4;
  localparam int unsigned DEF_NDATA  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // Bubble: an all-zero control word has no side effects downstream
  localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0]           ctrl;
    logic [DEF_RIDX_W-1:0]           ra;
    logic [DEF_RIDX_W-1:0]           rb;
    logic [DEF_NDATA*DEF_DATA_W-1:0] data;
    logic [DEF_IMM_W-1:0]            imm;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Used for stall accounting in pipe_stage_reg.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// ID/EX stage register with valid/ready handshake and bubble flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer build.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned RIDX_W = DEF_RIDX_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NDATA  = DEF_NDATA,
  parameter int unsigned IMM_W  = DEF_IMM_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [RIDX_W-1:0]       in_ra,
  input  logic [RIDX_W-1:0]       in_rb,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [IMM_W-1:0]        in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [RIDX_W-1:0]       out_ra,
  output logic [RIDX_W-1:0]       out_rb,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [IMM_W-1:0]        out_imm,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]       ctrl;
    logic [RIDX_W-1:0]       ra;
    logic [RIDX_W-1:0]       rb;
    logic [NDATA*DATA_W-1:0] data;
    logic [IMM_W-1:0]        imm;
  } pay_t;

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  pipe_state_t r_state;
  pay_t        r_main;
  pay_t        w_in;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_stall;

  assign w_in       = {in_ctrl, in_ra, in_rb, in_data, in_imm};
  assign out_valid  = (r_state != EMPTY);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
  pay_t r_skid;

  // Registered ready: no combinational path from out_ready
  assign in_ready = (r_state != SKID);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main.ctrl <= NOP;
      r_skid.ctrl <= NOP;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= w_in;
            r_state <= FULL;
          end
        end
        FULL: begin
          unique case ({w_in_xfer, w_out_xfer})
            2'b11: r_main <= w_in;
            2'b10: begin
              r_skid  <= w_in;
              r_state <= SKID;
            end
            2'b01: r_state <= EMPTY;
            default: r_state <= FULL;
          endcase
        end
        SKID: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= FULL;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  // In FULL an in xfer implies out_ready, so reload covers both cases
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main.ctrl <= NOP;
    end else if (w_in_xfer) begin
      r_main  <= w_in;
      r_state <= FULL;
    end else if (w_out_xfer) begin
      r_state <= EMPTY;
    end
  end
`endif

  assign out_ctrl = r_main.ctrl;
  assign out_ra   = r_main.ra;
  assign out_rb   = r_main.rb;
  assign out_data = r_main.data;
  assign out_imm  = r_main.imm;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; adapts expectations to
// whether PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_reg;

  localparam int DW = 5 * 32;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [14:0]   in_ctrl;
  logic [3:0]    in_ra;
  logic [3:0]    in_rb;
  logic [DW-1:0] in_data;
  logic [3:0]    in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [14:0]   out_ctrl;
  logic [3:0]    out_ra;
  logic [3:0]    out_rb;
  logic [DW-1:0] out_data;
  logic [3:0]    out_imm;
  logic [3:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_data   (in_data),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_ra    (out_ra),
    .out_rb    (out_rb),
    .out_data  (out_data),
    .out_imm   (out_imm),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [14:0] ctrl;
    logic [31:0] d0;
    logic        ev;
    logic [14:0] ec;
    logic [31:0] ed;
    logic [3:0]  en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic f,
                              input logic v, input logic y,
                              input logic [14:0] c, input logic [31:0] d,
                              input logic ev, input logic [14:0] ec,
                              input logic [31:0] ed, input logic [3:0] en);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.rdy = y;
    t.ctrl = c; t.d0 = d;
    t.ev = ev; t.ec = ec; t.ed = ed; t.en = en;
    return t;
  endfunction

  // Operand payload derived from a seed word; seed 0 means all-zero
  function automatic logic [DW-1:0] dat(input logic [31:0] d0);
    logic [DW-1:0] r;
    r = '0;
    if (d0 != 0)
      for (int k = 0; k < 5; k++)
        r[k*32 +: 32] = d0 + 32'(k) * 32'h1000;
    return r;
  endfunction

  function automatic logic [3:0] imm_of(input logic [31:0] d0);
    return (d0 == 0) ? 4'h0 : (d0[3:0] ^ 4'hF);
  endfunction

  task automatic drive(input logic v, input logic [14:0] c,
                       input logic [31:0] d, input logic y);
    in_valid  = v;
    in_ctrl   = c;
    in_ra     = d[3:0];
    in_rb     = d[7:4];
    in_imm    = imm_of(d);
    in_data   = dat(d);
    out_ready = y;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev,
                         input logic [14:0] ec, input logic [31:0] ed,
                         input logic [3:0] en);
    chk({tag, ".valid"}, DW'(out_valid), DW'(ev));
    chk({tag, ".ctrl"},  DW'(out_ctrl),  DW'(ec));
    chk({tag, ".ra"},    DW'(out_ra),    DW'(ed[3:0]));
    chk({tag, ".rb"},    DW'(out_rb),    DW'(ed[7:4]));
    chk({tag, ".imm"},   DW'(out_imm),   DW'(imm_of(ed)));
    chk({tag, ".data"},  out_data,       dat(ed));
    chk({tag, ".cnt"},   DW'(stall_cnt), DW'(en));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // reset
    tbl.push_back(mk(1,0,0,0, 0, 0,        0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0, 0, 0,        0, 0, 0, 0));
    // streaming ctrl 1..10, one cycle latency, no gaps
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,1,1, 15'(i+1), 32'hA0 + 32'(i),
                       1, 15'(i+1), 32'hA0 + 32'(i), 0));
    tbl.push_back(mk(0,0,0,1, 0, 0,        0, 10, 32'hA9, 0));
    tbl.push_back(mk(1,0,0,0, 0, 0,        0, 0, 0, 0));
    // flush beats in xfer; stall_cnt survives flush
    tbl.push_back(mk(0,0,1,1, 7, 32'h77,   1, 7, 32'h77, 0));
    tbl.push_back(mk(0,0,1,0, 8, 32'h88,   1, 7, 32'h77, 1));
    tbl.push_back(mk(0,1,1,0, 9, 32'h99,   0, 0, 32'h77, 2));
    tbl.push_back(mk(0,1,1,1, 9, 32'h99,   0, 0, 32'h77, 2));
    tbl.push_back(mk(0,0,0,1, 9, 32'h99,   0, 0, 32'h77, 2));

    #1;
    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      flush = tbl[i].flush;
      drive(tbl[i].vld, tbl[i].ctrl, tbl[i].d0, tbl[i].rdy);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec,
              tbl[i].ed, tbl[i].en);
    end

    // reset release: ready immediately
    flush = 1'b0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst.in_ready", DW'(in_ready), DW'(1));
    chk_out("rst", 0, 0, 0, 0);

    // stall with a word arriving while FULL
    drive(1'b1, 3, 32'h33, 1'b1);
    step();
    chk_out("st1", 1, 3, 32'h33, 0);
    drive(1'b1, 4, 32'h44, 1'b0);
    #1;
    chk("st2.in_ready", DW'(in_ready), DW'(SKID));
    step();
    chk_out("st2", 1, 3, 32'h33, 1);
    chk("st2.in_ready_after", DW'(in_ready), DW'(0));
    in_valid = SKID ? 1'b0 : 1'b1;
    step();
    chk_out("st3", 1, 3, 32'h33, 2);
    chk("st3.in_ready", DW'(in_ready), DW'(0));
    out_ready = 1'b1;
    #1;
    chk("st4.in_ready", DW'(in_ready), DW'(!SKID));
    step();
    chk_out("st4", 1, 4, 32'h44, 2);
    in_valid = 1'b0;
    step();
    chk_out("st5", 0, 4, 32'h44, 2);

    // saturation of the 4-bit stall counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 5, 32'h55, 1'b1);
    step();
    chk_out("sat0", 1, 5, 32'h55, 0);
    drive(1'b0, 5, 32'h55, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat%0d.cnt", i+1), DW'(stall_cnt),
          DW'((i + 1 > 15) ? 15 : i + 1));
    end
    chk_out("sat_end", 1, 5, 32'h55, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
